// File: rtl/funct_generator_fifo_pkg.sv
// Shared defaults and the status bundle for consumers of the function-generator FIFO.
package funct_generator_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_AFULL_THR  = 12;
    localparam int FIFO_AEMPTY_THR = 2;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic unf;
    } fifo_status_t;

    function automatic fifo_status_t pack_status(
        input logic full,
        input logic empty,
        input logic afull,
        input logic aempty,
        input logic ovf,
        input logic unf
    );
        fifo_status_t s;
        s.full   = full;
        s.empty  = empty;
        s.afull  = afull;
        s.aempty = aempty;
        s.ovf    = ovf;
        s.unf    = unf;
        return s;
    endfunction

endpackage

// File: rtl/funct_generator_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port. Array is not reset;
// only the read-data register is, so a freshly reset FIFO presents zero.
module funct_generator_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-first: a push and pop to the same slot (full FIFO) returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/funct_generator_fifo.sv
// Synchronous FIFO buffering function-generator samples for a downstream consumer,
// with registered level flags and sticky overflow/underflow indicators.
module funct_generator_fifo
    import funct_generator_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int AFULL_THR  = FIFO_AFULL_THR,
    parameter int AEMPTY_THR = FIFO_AEMPTY_THR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    input  logic                  clr_err_i,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THR);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THR);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [ADDR_WIDTH:0] r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_afull;
    logic                r_aempty;
    logic                r_valid;
    logic                r_ovf;
    logic                r_unf;

    logic                w_push_ok;
    logic                w_pop_ok;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic [ADDR_WIDTH:0] w_count_next;
    logic [DATA_WIDTH-1:0] w_rdata;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    assign w_pop_ok  = rd_en_i & ~r_empty;
    assign w_push_ok = wr_en_i & (~r_full | w_pop_ok);
    assign w_ovf_set = wr_en_i & ~w_push_ok;
    assign w_unf_set = rd_en_i & r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_next = r_count + ONE_C;
            2'b01:   w_count_next = r_count - ONE_C;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ONE_C;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ONE_C;
            end
            r_count  <= w_count_next;
            // Flags come from the next count so they line up with count_o.
            r_full   <= (w_count_next == DEPTH_C);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= AFULL_C);
            r_aempty <= (w_count_next <= AEMPTY_C);
            r_valid  <= w_pop_ok;
        end
    end

    // Sticky errors: a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err_i);
            r_unf <= w_unf_set | (r_unf & ~clr_err_i);
        end
    end

    funct_generator_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_push_ok & ~rst),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (data_i),
        .i_re    (w_pop_ok & ~rst),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    assign data_o         = w_rdata;
    assign valid_o        = r_valid;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign count_o        = r_count;
    assign overflow_o     = r_ovf;
    assign underflow_o    = r_unf;

endmodule

// File: tb/tb_funct_generator_fifo.sv
// Directed bench for funct_generator_fifo: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of each scenario.
module tb_funct_generator_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        rd_en_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        full_o;
    logic        empty_o;
    logic        almost_full_o;
    logic        almost_empty_o;
    logic [4:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_assert = 0;
    int n_fail   = 0;

    funct_generator_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en_i),
        .data_i         (data_i),
        .rd_en_i        (rd_en_i),
        .data_o         (data_o),
        .valid_o        (valid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .clr_err_i      (clr_err_i),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored samples plus the last popped word.
    logic [31:0] m_q[$];
    logic [31:0] m_data  = '0;
    logic        m_valid = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_unf   = 1'b0;
    logic        m_ready = 1'b0;

    always @(posedge clk) begin
        bit pop_ok, push_ok;
        if (rst) begin
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_ready = 1'b1;
        end else begin
            pop_ok  = rd_en_i && (m_q.size() > 0);
            push_ok = wr_en_i && ((m_q.size() < 16) || pop_ok);
            m_ovf   = (wr_en_i && !push_ok) || (m_ovf && !clr_err_i);
            m_unf   = (rd_en_i && m_q.size() == 0) || (m_unf && !clr_err_i);
            m_valid = pop_ok;
            if (pop_ok) m_data = m_q.pop_front();
            if (push_ok) m_q.push_back(data_i);
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_data_o",   data_o, m_data);
            check("m_valid_o",  32'(valid_o), 32'(m_valid));
            check("m_count_o",  32'(count_o), m_q.size());
            check("m_full_o",   32'(full_o), 32'(m_q.size() == 16));
            check("m_empty_o",  32'(empty_o), 32'(m_q.size() == 0));
            check("m_afull_o",  32'(almost_full_o), 32'(m_q.size() >= 12));
            check("m_aempty_o", 32'(almost_empty_o), 32'(m_q.size() <= 2));
            check("m_ovf_o",    32'(overflow_o), 32'(m_ovf));
            check("m_unf_o",    32'(underflow_o), 32'(m_unf));
        end
    end

    // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
    task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
        wr_en_i   = wr;
        data_i    = d;
        rd_en_i   = rd;
        clr_err_i = clr;
        @(negedge clk);
        $display("step wr=%0b d=0x%0h rd=%0b clr=%0b -> cnt=%0d dout=0x%0h v=%0b ovf=%0b unf=%0b",
                 wr, d, rd, clr, count_o, data_o, valid_o, overflow_o, underflow_o);
    endtask

    initial begin
        logic [31:0] exp_d;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_empty",  32'(empty_o), 1);
        check("rst_full",   32'(full_o), 0);
        check("rst_count",  32'(count_o), 0);
        check("rst_data",   data_o, 0);
        check("rst_valid",  32'(valid_o), 0);
        check("rst_ovf",    32'(overflow_o), 0);
        check("rst_unf",    32'(underflow_o), 0);
        check("rst_aempty", 32'(almost_empty_o), 1);
        rst = 1'b0;

        // Ordering
        step(1, 32'h1, 0, 0);
        step(1, 32'h2, 0, 0);
        step(1, 32'h3, 0, 0);
        check("ord_count", 32'(count_o), 3);
        step(0, 0, 1, 0);
        check("ord_d1", data_o, 32'h1);
        check("ord_v1", 32'(valid_o), 1);
        step(0, 0, 1, 0);
        check("ord_d2", data_o, 32'h2);
        step(0, 0, 1, 0);
        check("ord_d3", data_o, 32'h3);
        check("ord_empty", 32'(empty_o), 1);
        step(0, 0, 0, 0);
        check("ord_vdrop", 32'(valid_o), 0);
        check("ord_hold", data_o, 32'h3);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            step(1, 32'hA0 + 32'(i), 0, 0);
            check("fill_afull", 32'(almost_full_o), 32'(i + 1 >= 12));
            check("fill_full",  32'(full_o), 32'(i == 15));
        end
        step(1, 32'hFF, 0, 0);
        check("ovf_flag",  32'(overflow_o), 1);
        check("ovf_count", 32'(count_o), 16);

        // Push and pop together while full
        step(1, 32'h55, 1, 0);
        check("conc_count", 32'(count_o), 16);
        check("conc_full",  32'(full_o), 1);
        check("conc_data",  data_o, 32'hA0);
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 1, 0);
            exp_d = (k < 15) ? (32'hA1 + 32'(k)) : 32'h55;
            check("drain_data", data_o, exp_d);
        end
        check("drain_empty", 32'(empty_o), 1);
        step(0, 0, 0, 1);
        check("clr_ovf", 32'(overflow_o), 0);

        // Empty corner cases
        step(0, 0, 1, 0);
        check("unf_flag",  32'(underflow_o), 1);
        check("unf_valid", 32'(valid_o), 0);
        step(0, 0, 0, 1);
        check("unf_clr", 32'(underflow_o), 0);
        step(1, 32'h7, 1, 0);
        check("pe_count", 32'(count_o), 1);
        check("pe_unf",   32'(underflow_o), 1);
        step(0, 0, 1, 1);
        check("clr_pop_unf", 32'(underflow_o), 0);
        check("pe_data",     data_o, 32'h7);
        step(0, 0, 1, 1);
        check("clr_set_wins", 32'(underflow_o), 1);
        step(0, 0, 0, 1);
        check("clr_alone_unf", 32'(underflow_o), 0);
        check("clr_alone_ovf", 32'(overflow_o), 0);

        // Pointer wrap with random data
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 40; i++) step(1, $urandom, 1, 0);
        check("wrap_count", 32'(count_o), 3);
        for (int i = 0; i < 2; i++) step(1, $urandom, 0, 0);
        check("pre_rst_count", 32'(count_o), 5);
        rst = 1'b1;
        step(0, 0, 0, 0);
        rst = 1'b0;
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_empty", 32'(empty_o), 1);

        // Generator-style producer at half rate, consumer popping every cycle
        for (int k = 0; k < 40; k++) begin
            step((k % 2) == 0, 32'h0001_0000 * 32'(k), 1, 0);
        end
        step(0, 0, 0, 0);
        check("gen_no_ovf", 32'(overflow_o), 0);
        check("gen_last",   data_o, 32'h0001_0000 * 32'd38);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
